// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues in-order imem requests, buffers returned instructions in a
// small entry FIFO and feeds the IF/ID register; a redirect flushes and kills in-flight returns.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_pc,
    input  logic            stall_if_id,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc_plus4
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_ent_pc    [DEPTH];
    logic [XLEN-1:0]  r_ent_instr [DEPTH];
    logic [DEPTH-1:0] r_ent_filled;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW-1:0]    r_fill;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_unfilled;
    logic [CW-1:0]    r_kill;
    logic             r_if_valid;
    logic [XLEN-1:0]  r_if_pc;
    logic [XLEN-1:0]  r_if_instr;
    logic [XLEN-1:0]  r_if_pc_plus4;

    logic             w_req_valid;
    logic             w_accept;
    logic             w_rsp_kill;
    logic             w_rsp_fill;
    logic             w_head_ready;
    logic             w_pop;
    logic [CW-1:0]    w_count_next;
    logic [CW-1:0]    w_unfilled_next;

    // The request side looks only at the registered count, so a full FIFO that pops this
    // cycle still issues nothing until the next one.
    assign w_req_valid  = !rst && !stall_pc && !redirect_valid && (r_count < CW'(DEPTH));
    assign w_accept     = w_req_valid && imem_req_ready;
    assign w_rsp_kill   = imem_rsp_valid && (r_kill != '0);
    assign w_rsp_fill   = imem_rsp_valid && (r_kill == '0);
    assign w_head_ready = (r_count != '0) && r_ent_filled[r_head];
    assign w_pop        = !redirect_valid && !stall_if_id && w_head_ready;

    assign w_count_next    = r_count + CW'(w_accept) - CW'(w_pop);
    assign w_unfilled_next = r_unfilled + CW'(w_accept) - CW'(w_rsp_fill);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_ent_filled  <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_fill        <= '0;
            r_count       <= '0;
            r_unfilled    <= '0;
            r_kill        <= '0;
            r_if_valid    <= 1'b0;
            r_if_pc       <= '0;
            r_if_instr    <= '0;
            r_if_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            r_pc         <= redirect_pc;
            r_ent_filled <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_fill       <= '0;
            r_count      <= '0;
            r_unfilled   <= '0;
            // Every old-path response still owed must be dropped, minus the one arriving now.
            r_kill       <= r_kill + r_unfilled - CW'(imem_rsp_valid);
            r_if_valid   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pc                 <= r_pc + XLEN'(4);
                r_ent_pc[r_tail]     <= r_pc;
                r_ent_filled[r_tail] <= 1'b0;
                r_tail               <= r_tail + AW'(1);
            end
            if (w_rsp_kill) begin
                r_kill <= r_kill - CW'(1);
            end
            if (w_rsp_fill) begin
                r_ent_instr[r_fill]  <= imem_rsp_data;
                r_ent_filled[r_fill] <= 1'b1;
                r_fill               <= r_fill + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            r_count    <= w_count_next;
            r_unfilled <= w_unfilled_next;
            if (!stall_if_id) begin
                if (w_head_ready) begin
                    r_if_valid    <= 1'b1;
                    r_if_pc       <= r_ent_pc[r_head];
                    r_if_instr    <= r_ent_instr[r_head];
                    r_if_pc_plus4 <= r_ent_pc[r_head] + XLEN'(4);
                end else begin
                    r_if_valid <= 1'b0;
                end
            end
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign if_id_valid    = r_if_valid;
    assign if_id_pc       = r_if_pc;
    assign if_id_instr    = r_if_instr;
    assign if_id_pc_plus4 = r_if_pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model, stream-level reference model of the PC sequence,
// a per-cycle vector table for the startup/stall sequence, directed redirect cases, random phase.
module tb_fetch_unit;

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_pc = 1'b0;
    logic        stall_if_id = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall_pc       (stall_pc),
        .stall_if_id    (stall_if_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory: in order, one response per cycle, fixed latency (1..3) after accept.
    typedef struct {
        logic [31:0] addr;
        longint      due;
    } mreq_t;

    mreq_t  mq[$];
    int     lat = 1;
    longint cyc = 0;
    longint last_due = 0;

    initial begin
        longint due;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
                last_due = 0;
            end else if (imem_req_valid && imem_req_ready) begin
                due = cyc + longint'(lat);
                if (due <= last_due) due = last_due + 1;
                mq.push_back('{addr: imem_req_addr, due: due});
                last_due = due;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (mq.size() != 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mq[0].addr ^ MAGIC;
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Reference model: requests walk pc, pc+4, ... from the last reset/redirect target, and the
    // valid IF/ID stream must walk the same sequence with no loss, duplication or wrong path.
    logic [31:0] m_req_pc = '0;
    logic [31:0] m_if_pc = '0;
    logic        m_prev_rst = 1'b1;
    logic        m_prev_hold = 1'b0;
    logic        m_prev_redir = 1'b0;
    logic        m_prev_valid = 1'b0;
    int          delivered = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
        end else begin
            if (stall_pc || redirect_valid) chk("req_blocked", 32'(imem_req_valid), 32'd0);
            if (imem_req_valid) chk("req_addr", imem_req_addr, m_req_pc);
        end
        if (m_prev_rst) begin
            chk("reset_if_valid", 32'(if_id_valid), 32'd0);
            chk("reset_if_pc", if_id_pc, 32'd0);
            chk("reset_if_instr", if_id_instr, 32'd0);
            chk("reset_if_pc_plus4", if_id_pc_plus4, 32'd0);
        end else if (m_prev_redir) begin
            chk("if_valid_after_redirect", 32'(if_id_valid), 32'd0);
        end else if (m_prev_hold) begin
            chk("hold_valid", 32'(if_id_valid), 32'(m_prev_valid));
            if (if_id_valid) begin
                chk("hold_pc", if_id_pc, m_if_pc - 32'd4);
                chk("hold_instr", if_id_instr, (m_if_pc - 32'd4) ^ MAGIC);
                chk("hold_pc_plus4", if_id_pc_plus4, m_if_pc);
            end
        end else if (if_id_valid) begin
            chk("stream_pc", if_id_pc, m_if_pc);
            chk("stream_instr", if_id_instr, m_if_pc ^ MAGIC);
            chk("stream_pc_plus4", if_id_pc_plus4, m_if_pc + 32'd4);
            m_if_pc = m_if_pc + 32'd4;
            delivered++;
        end
        if (rst) begin
            m_req_pc = 32'h0;
            m_if_pc  = 32'h0;
        end else if (redirect_valid) begin
            m_req_pc = redirect_pc;
            m_if_pc  = redirect_pc;
        end else if (imem_req_valid && imem_req_ready) begin
            m_req_pc = m_req_pc + 32'd4;
        end
        m_prev_rst   = rst;
        m_prev_redir = !rst && redirect_valid;
        m_prev_hold  = !rst && !redirect_valid && stall_if_id;
        m_prev_valid = if_id_valid;
    end

    task automatic do_reset();
        rst            = 1'b1;
        stall_pc       = 1'b0;
        stall_if_id    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget,
                              output logic [31:0] pc, output logic [31:0] p4);
        bit found = 0;
        int n = 0;
        pc = '0;
        p4 = '0;
        while (!found && n < budget) begin
            @(negedge clk);
            if (if_id_valid) begin
                found = 1;
                pc = if_id_pc;
                p4 = if_id_pc_plus4;
            end else begin
                tick();
                n++;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: no if_id_valid within %0d cycles, expected one", name, budget);
        end
    endtask

    typedef struct {
        logic        spc;
        logic        sif;
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] ip;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [31:0] pc;
        logic [31:0] p4;
        int          r;

        // 1-cycle memory from reset; the registered-count rule gives 2 of every 3 cycles valid.
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h18};

        lat = 1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            stall_pc    = tbl[i].spc;
            stall_if_id = tbl[i].sif;
            @(negedge clk);
            chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].rv));
            if (tbl[i].rv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].ra);
            chk($sformatf("vec%0d_if_valid", i), 32'(if_id_valid), 32'(tbl[i].iv));
            if (tbl[i].iv) begin
                chk($sformatf("vec%0d_if_pc", i), if_id_pc, tbl[i].ip);
                chk($sformatf("vec%0d_if_instr", i), if_id_instr, tbl[i].ip ^ MAGIC);
                chk($sformatf("vec%0d_if_pc_plus4", i), if_id_pc_plus4, tbl[i].ip + 32'd4);
            end
            tick();
        end

        // Redirect with two 3-cycle requests outstanding: both are dropped.
        lat = 3;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("s3_req_a", imem_req_addr, 32'h10);
        tick();
        @(negedge clk);
        chk("s3_req_b", imem_req_addr, 32'h14);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        wait_valid("s3_first", 30, pc, p4);
        chk("s3_first_pc", pc, 32'h100);

        // Redirect in the same cycle the response for 0x10 arrives, 0x14 still owed.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        wait_valid("s4_first", 30, pc, p4);
        chk("s4_first_pc", pc, 32'h200);

        // Back-pressure: address holds at 0x20 while ready is low.
        lat = 1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("s5_hold%0d_valid", k), 32'(imem_req_valid), 32'd1);
            chk($sformatf("s5_hold%0d_addr", k), imem_req_addr, 32'h20);
            tick();
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("s5_accept_addr", imem_req_addr, 32'h20);
        tick();
        @(negedge clk);
        chk("s5_next_addr", imem_req_addr, 32'h24);

        // PC wrap at the top of the address space.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("s6_req_top", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        chk("s6_req_wrap", imem_req_addr, 32'h0);
        wait_valid("s6_first", 20, pc, p4);
        chk("s6_if_pc", pc, 32'hFFFF_FFFC);
        chk("s6_if_pc_plus4", p4, 32'h0);

        // Random stalls, back-pressure, redirects and latency, checked by the stream model.
        do_reset();
        delivered = 0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) lat = int'($urandom_range(1, 3));
            r = int'($urandom_range(0, 99));
            redirect_valid = (r < 6);
            if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
            else redirect_pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            r = int'($urandom_range(0, 99));
            stall_pc       = (r < 28);
            stall_if_id    = (r < 20);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        redirect_valid = 1'b0;
        stall_pc       = 1'b1;
        stall_if_id    = 1'b0;
        imem_req_ready = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        #1;
        chk("drain_all_delivered", m_if_pc, m_req_pc);
        chk("random_progress", 32'(delivered > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
